// File: rtl/proc_pkg.sv
// Shared widths, halt encoding, fetch FSM encoding and branch-target table
// for the 9-bit processor front end.
package proc_pkg;

  localparam int PC_W      = 10;
  localparam int MCODEBITS = 9;
  localparam int LUT_AW    = 4;
  localparam int CNT_W     = 16;

  localparam logic [MCODEBITS-1:0] HALT_WORD = 9'h1FF;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_RUN  = 2'd1,
    FS_DONE = 2'd2
  } fetch_state_t;

  // Absolute branch targets, indexed by the low LUT_AW bits of the branch word.
  localparam logic [PC_W-1:0] BRANCH_LUT [16] = '{
    10'd0,   10'd16,  10'd32,  10'd48,
    10'd64,  10'd40,  10'd96,  10'd112,
    10'd128, 10'd1023, 10'd160, 10'd176,
    10'd192, 10'd208, 10'd224, 10'd240
  };

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: program control and branch inputs in, PC/instruction/status out.
interface instr_fetch_if;
  import proc_pkg::*;

  logic                 start;
  logic                 stall;
  logic                 branch_en;
  logic                 branch_taken;
  logic [MCODEBITS-1:0] instr_in;
  logic [PC_W-1:0]      pc_out;
  logic [MCODEBITS-1:0] instr_out;
  logic                 instr_valid;
  logic                 done;
  logic [CNT_W-1:0]     cycle_count;

  modport master (
    output start, stall, branch_en, branch_taken, instr_in,
    input  pc_out, instr_out, instr_valid, done, cycle_count
  );

  modport slave (
    input  start, stall, branch_en, branch_taken, instr_in,
    output pc_out, instr_out, instr_valid, done, cycle_count
  );

endinterface

// File: rtl/branch_lut.sv
// Combinational branch-target ROM; index -> absolute PC, no added latency.
module branch_lut
  import proc_pkg::*;
(
  input  logic [LUT_AW-1:0] i_idx,
  output logic [PC_W-1:0]   o_target
);

  assign o_target = BRANCH_LUT[i_idx];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns PC, picks sequential/branch/hold next PC, runs start/done
// program handshake and a saturating RUN-cycle counter. Next PC visible one cycle later.
module instr_fetch
  import proc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  instr_fetch_if.slave bus
);

  fetch_state_t     r_state;
  logic [PC_W-1:0]  r_pc;
  logic [CNT_W-1:0] r_cnt;

  logic             w_halt;
  logic [PC_W-1:0]  w_target;
  logic [PC_W-1:0]  w_pc_next;

  branch_lut u_lut (
    .i_idx    (bus.instr_in[LUT_AW-1:0]),
    .o_target (w_target)
  );

  assign w_halt = (bus.instr_in == HALT_WORD);

  always_comb begin
    w_pc_next = r_pc + PC_W'(1);
    if (w_halt)
      w_pc_next = r_pc;
    else if (bus.branch_en && bus.branch_taken)
      w_pc_next = w_target;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FS_IDLE;
      r_pc    <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        FS_IDLE: begin
          if (bus.start) begin
            r_state <= FS_RUN;
            r_pc    <= '0;
            r_cnt   <= '0;
          end
        end
        FS_RUN: begin
          // A stall freezes everything; branch/halt are re-evaluated next cycle.
          if (!bus.stall) begin
            r_pc  <= w_pc_next;
            r_cnt <= (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);
            if (w_halt)
              r_state <= FS_DONE;
          end
        end
        FS_DONE: begin
          if (bus.start) begin
            r_state <= FS_RUN;
            r_pc    <= '0;
            r_cnt   <= '0;
          end
        end
        default: r_state <= FS_IDLE;
      endcase
    end
  end

  assign bus.pc_out      = r_pc;
  assign bus.instr_out   = bus.instr_in;
  assign bus.instr_valid = (r_state == FS_RUN);
  assign bus.done        = (r_state == FS_DONE);
  assign bus.cycle_count = r_cnt;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

- Fetch stage of the 9-bit processor.
- Owns the program counter and addresses instruction memory.
- Presents the current 9-bit machine word to the control decoder.
- Computes next PC: sequential, taken branch through a branch-target lookup table, or hold on stall.
- Runs a start/done program handshake and counts executed cycles for the testbench.

## Interface
- PC_W, 10, program counter / instruction memory address width
- MCODEBITS, 9, instruction word width (matches control decoder `mcodebits`)
- LUT_AW, 4, branch LUT index width; index taken from instr[3:0]
- HALT_WORD, 9'h1FF, machine word that ends a program
- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a program at PC 0
- stall  in  1  hold PC and current instruction this cycle
- branch_en  in  1  `Branch` from control decoder
- branch_taken  in  1  branch condition from ALU/flags
- instr_in  in  MCODEBITS  word read from instruction memory at pc_out (combinational read)
- pc_out  out  PC_W  current program counter
- instr_out  out  MCODEBITS  instruction to control decoder (= instr_in)
- instr_valid  out  1  high only in RUN
- done  out  1  program finished; held until next start or reset
- cycle_count  out  16  RUN cycles since last start; saturates at 16'hFFFF

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - pc_out = 0, instr_valid = 0.
  - start -> RUN; PC stays 0, so the first executed instruction is address 0.
- RUN, evaluated each cycle in this priority:
  1. stall: PC, state and cycle_count unchanged. Branch and halt are ignored this cycle and re-evaluated next cycle from the same instruction.
  2. instr_in == HALT_WORD: go to DONE; PC unchanged.
  3. branch_en && branch_taken: PC <= lut[instr_in[LUT_AW-1:0]] (absolute target).
  4. Otherwise PC <= PC + 1, modulo 2^PC_W (1023 -> 0 wraps silently).
- cycle_count increments in every non-stalled RUN cycle, including the halt cycle; it saturates and does not wrap.
- branch_en with branch_taken = 0 behaves as sequential.
- DONE:
  - done = 1, instr_valid = 0, pc_out holds the halt address.
  - start -> RUN with PC <= 0 and cycle_count <= 0; done drops the same edge.
- start in RUN is ignored.
- reset at any time, including mid-program: state IDLE, PC 0, cycle_count 0, done 0, on that edge.

## Timing
- All state updates on the rising clk edge; reset has priority over every other input.
- Reset values: pc_out 0, instr_valid 0, done 0, cycle_count 0; instr_out follows instr_in.
- Latency:
  - Next-PC decision uses same-cycle instr_in, branch_en and branch_taken.
  - New PC is visible on pc_out one cycle later; the new instruction appears the same cycle (combinational imem).
  - A taken branch costs zero bubbles.
- start -> instr_valid high the next cycle, with pc_out = 0.
- Halt fetched in cycle N -> done high in cycle N+1. The halt word itself is not counted as executed by the decoder: RegWrite/MemWrite are gated by instr_valid downstream.
- Branch LUT is combinational; no added latency.

## Structure
- Shared package `proc_pkg` holds:
  - FSM enum `fetch_state_t`
  - HALT_WORD and widths
  - branch LUT contents as a constant array `BRANCH_LUT[16]` of PC_W entries
- Sub-module `branch_lut`: combinational ROM, index LUT_AW bits -> PC_W-bit target, filled from proc_pkg.
- Rest is a single always_ff for PC/state/counter plus a small always_comb next-PC mux.

## Test plan
- Reset then start; imem holds three non-branch words then 9'h1FF at address 3 -> pc_out 0,1,2,3; done high the cycle after PC 3; cycle_count = 4.
- BRANCH_LUT[5] = 40; word at address 2 has instr[3:0] = 5, branch_en = 1, branch_taken = 1 -> next pc_out = 40. Repeat with branch_taken = 0 -> next pc_out = 3.
- stall held 3 cycles at PC 7 while a taken branch is present -> pc_out stays 7 and cycle_count stays frozen; stall released -> branch target loaded next cycle.
- PC at 1023 with a sequential word -> pc_out wraps to 0; no done asserted.
- Synchronous reset asserted mid-run at PC 12 -> next edge pc_out 0, IDLE, done 0, cycle_count 0; start ignored while reset is high.
- Program finished (done = 1, pc_out = 3); pulse start -> pc_out 0, done 0, cycle_count 0, instr_valid 1 the next cycle.
